// File: rtl/cmul_arbiter.sv
// cmul_arbiter
// Two-requester arbiter and sequencer in front of a single comp_mul
// complex multiplier. Each cycle at most one operand pair is accepted,
// registered onto the multiplier inputs, and tagged with its requester id.
// The tag travels down a MUL_LAT+1 deep pipeline that lines up with the
// multiplier latency. When the tag reaches the head, the product is routed
// back to the requester that issued it.
//
// Build option: CMUL_ARB_RR_EN
//   defined     -> round-robin arbitration with a 1-bit last-grant pointer
//   not defined -> fixed priority, requester 0 always wins a tie
//
// Handshake: a request transfers on a rising edge where reqN_valid and
// reqN_ready are both high. Ready is a pure function of the two valids,
// the arbitration pointer and reset, and never looks at downstream state.
// Responses are one-cycle strobes with no backpressure.
module cmul_arbiter #(
    parameter int MUL_LAT = 2  // comp_mul latency, legal range 1..8
) (
    input  logic               clk,
    input  logic               rst,

    // requester 0
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic signed [7:0]  req0_ar,
    input  logic signed [7:0]  req0_ai,
    input  logic signed [7:0]  req0_br,
    input  logic signed [7:0]  req0_bi,

    // requester 1
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic signed [7:0]  req1_ar,
    input  logic signed [7:0]  req1_ai,
    input  logic signed [7:0]  req1_br,
    input  logic signed [7:0]  req1_bi,

    // comp_mul side
    output logic               mul_en,
    output logic signed [7:0]  mul_ar,
    output logic signed [7:0]  mul_ai,
    output logic signed [7:0]  mul_br,
    output logic signed [7:0]  mul_bi,
    input  logic signed [16:0] mul_or,
    input  logic signed [16:0] mul_oi,

    // responses
    output logic               rsp0_valid,
    output logic signed [16:0] rsp0_r,
    output logic signed [16:0] rsp0_i,
    output logic               rsp1_valid,
    output logic signed [16:0] rsp1_r,
    output logic signed [16:0] rsp1_i,

    output logic               idle
);

    // Stage 0 is loaded on the accept edge; stage MUL_LAT is the head and
    // is valid in the same cycle the multiplier presents that product.
    localparam int TAG_N = MUL_LAT + 1;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic                grant0;
    logic                grant1;
    logic                xfer;
    logic                xfer_id;

    logic [TAG_N-1:0]    tag_vld_q;
    logic [TAG_N-1:0]    tag_vld_d;
    logic [TAG_N-1:0]    tag_id_q;
    logic [TAG_N-1:0]    tag_id_d;
    logic                head_vld;
    logic                head_id;

    logic                mul_en_q;
    logic                mul_en_d;
    logic signed [7:0]   mul_ar_q;
    logic signed [7:0]   mul_ar_d;
    logic signed [7:0]   mul_ai_q;
    logic signed [7:0]   mul_ai_d;
    logic signed [7:0]   mul_br_q;
    logic signed [7:0]   mul_br_d;
    logic signed [7:0]   mul_bi_q;
    logic signed [7:0]   mul_bi_d;

    logic                rsp0_valid_q;
    logic                rsp0_valid_d;
    logic signed [16:0]  rsp0_r_q;
    logic signed [16:0]  rsp0_r_d;
    logic signed [16:0]  rsp0_i_q;
    logic signed [16:0]  rsp0_i_d;
    logic                rsp1_valid_q;
    logic                rsp1_valid_d;
    logic signed [16:0]  rsp1_r_q;
    logic signed [16:0]  rsp1_r_d;
    logic signed [16:0]  rsp1_i_q;
    logic signed [16:0]  rsp1_i_d;

`ifdef CMUL_ARB_RR_EN
    // Id of the most recent grant; the other requester wins the next tie.
    logic                last_q;
    logic                last_d;
`endif

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    // Combinational grant; nothing is granted while reset is asserted.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst) begin
`ifdef CMUL_ARB_RR_EN
            if (req0_valid && req1_valid) begin
                // Tie: grant whichever requester did not go last.
                grant0 = last_q;
                grant1 = ~last_q;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
`else
            // Fixed priority: requester 1 only wins when 0 is not asking.
            grant0 = req0_valid;
            grant1 = req1_valid & ~req0_valid;
`endif
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign xfer       = grant0 | grant1;
    assign xfer_id    = grant1;

`ifdef CMUL_ARB_RR_EN
    // Pointer follows the granted id on every transfer.
    always_comb begin
        last_d = last_q;
        if (xfer) begin
            last_d = xfer_id;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Tag pipeline
    // ------------------------------------------------------------------
    // Shift tags toward the head; an idle cycle inserts an invalid bubble.
    always_comb begin
        tag_vld_d = {tag_vld_q[TAG_N-2:0], xfer};
        tag_id_d  = {tag_id_q[TAG_N-2:0], xfer & xfer_id};
    end

    assign head_vld = tag_vld_q[TAG_N-1];
    assign head_id  = tag_id_q[TAG_N-1];

    // ------------------------------------------------------------------
    // Multiplier issue
    // ------------------------------------------------------------------
    // Load the granted operands; hold the last operands on idle cycles.
    always_comb begin
        mul_en_d = xfer;
        mul_ar_d = mul_ar_q;
        mul_ai_d = mul_ai_q;
        mul_br_d = mul_br_q;
        mul_bi_d = mul_bi_q;
        if (xfer) begin
            if (xfer_id) begin
                mul_ar_d = req1_ar;
                mul_ai_d = req1_ai;
                mul_br_d = req1_br;
                mul_bi_d = req1_bi;
            end else begin
                mul_ar_d = req0_ar;
                mul_ai_d = req0_ai;
                mul_br_d = req0_br;
                mul_bi_d = req0_bi;
            end
        end
    end

    // ------------------------------------------------------------------
    // Response capture
    // ------------------------------------------------------------------
    // Route the head product to its owner; the other side keeps its data.
    always_comb begin
        rsp0_valid_d = head_vld & ~head_id;
        rsp1_valid_d = head_vld & head_id;
        rsp0_r_d     = rsp0_r_q;
        rsp0_i_d     = rsp0_i_q;
        rsp1_r_d     = rsp1_r_q;
        rsp1_i_d     = rsp1_i_q;
        if (rsp0_valid_d) begin
            rsp0_r_d = mul_or;
            rsp0_i_d = mul_oi;
        end
        if (rsp1_valid_d) begin
            rsp1_r_d = mul_or;
            rsp1_i_d = mul_oi;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // All state, with synchronous reset discarding every in-flight tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld_q    <= '0;
            tag_id_q     <= '0;
            mul_en_q     <= 1'b0;
            mul_ar_q     <= '0;
            mul_ai_q     <= '0;
            mul_br_q     <= '0;
            mul_bi_q     <= '0;
            rsp0_valid_q <= 1'b0;
            rsp0_r_q     <= '0;
            rsp0_i_q     <= '0;
            rsp1_valid_q <= 1'b0;
            rsp1_r_q     <= '0;
            rsp1_i_q     <= '0;
`ifdef CMUL_ARB_RR_EN
            last_q       <= 1'b1;
`endif
        end else begin
            tag_vld_q    <= tag_vld_d;
            tag_id_q     <= tag_id_d;
            mul_en_q     <= mul_en_d;
            mul_ar_q     <= mul_ar_d;
            mul_ai_q     <= mul_ai_d;
            mul_br_q     <= mul_br_d;
            mul_bi_q     <= mul_bi_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp0_r_q     <= rsp0_r_d;
            rsp0_i_q     <= rsp0_i_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp1_r_q     <= rsp1_r_d;
            rsp1_i_q     <= rsp1_i_d;
`ifdef CMUL_ARB_RR_EN
            last_q       <= last_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mul_en     = mul_en_q;
    assign mul_ar     = mul_ar_q;
    assign mul_ai     = mul_ai_q;
    assign mul_br     = mul_br_q;
    assign mul_bi     = mul_bi_q;

    assign rsp0_valid = rsp0_valid_q;
    assign rsp0_r     = rsp0_r_q;
    assign rsp0_i     = rsp0_i_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp1_r     = rsp1_r_q;
    assign rsp1_i     = rsp1_i_q;

    // Idle once nothing is in the tag pipeline and no strobe is showing.
    assign idle = ~(|tag_vld_q) & ~rsp0_valid_q & ~rsp1_valid_q;

endmodule

// File: tb/tb_cmul_arbiter.sv
// Directed bench for cmul_arbiter with a two-cycle comp_mul model.
module tb_cmul_arbiter;

  localparam int MUL_LAT = 2;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic req0_valid, req1_valid;
  logic req0_ready, req1_ready;
  logic signed [7:0] req0_ar, req0_ai, req0_br, req0_bi;
  logic signed [7:0] req1_ar, req1_ai, req1_br, req1_bi;
  logic mul_en;
  logic signed [7:0] mul_ar, mul_ai, mul_br, mul_bi;
  logic signed [16:0] mul_or, mul_oi;
  logic rsp0_valid, rsp1_valid;
  logic signed [16:0] rsp0_r, rsp0_i, rsp1_r, rsp1_i;
  logic idle;

  int total = 0;
  int bad = 0;

  // per-cycle tables for the tie scenario, bit k = cycle k
  logic [10:0] v0_t, v1_t, rdy0_t, rdy1_t, r0v_t, r1v_t;

  cmul_arbiter #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_ar(req0_ar), .req0_ai(req0_ai), .req0_br(req0_br), .req0_bi(req0_bi),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_ar(req1_ar), .req1_ai(req1_ai), .req1_br(req1_br), .req1_bi(req1_bi),
    .mul_en(mul_en), .mul_ar(mul_ar), .mul_ai(mul_ai), .mul_br(mul_br), .mul_bi(mul_bi),
    .mul_or(mul_or), .mul_oi(mul_oi),
    .rsp0_valid(rsp0_valid), .rsp0_r(rsp0_r), .rsp0_i(rsp0_i),
    .rsp1_valid(rsp1_valid), .rsp1_r(rsp1_r), .rsp1_i(rsp1_i),
    .idle(idle)
  );

  // comp_mul model: product appears two cycles after the i_en cycle
  logic signed [16:0] p1_r, p1_i, p2_r, p2_i;
  always_ff @(posedge clk) begin
    if (rst) begin
      p1_r <= '0; p1_i <= '0; p2_r <= '0; p2_i <= '0;
    end else begin
      if (mul_en) begin
        p1_r <= 17'(int'(mul_ar) * int'(mul_br) - int'(mul_ai) * int'(mul_bi));
        p1_i <= 17'(int'(mul_ar) * int'(mul_bi) + int'(mul_ai) * int'(mul_br));
      end
      p2_r <= p1_r;
      p2_i <= p1_i;
    end
  end
  assign mul_or = p2_r;
  assign mul_oi = p2_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // advance one clock; inputs change and outputs are sampled 2 units after the edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req0(input int ar, input int ai, input int br, input int bi);
    req0_ar = 8'(ar); req0_ai = 8'(ai); req0_br = 8'(br); req0_bi = 8'(bi);
  endtask

  task automatic set_req1(input int ar, input int ai, input int br, input int bi);
    req1_ar = 8'(ar); req1_ai = 8'(ai); req1_br = 8'(br); req1_bi = 8'(bi);
  endtask

  initial begin
`ifdef CMUL_ARB_RR_EN
    v0_t   = 11'b00000001111;
    v1_t   = 11'b00000001111;
    rdy0_t = 11'b00000000101;
    rdy1_t = 11'b00000001010;
    r0v_t  = 11'b00001010000;
    r1v_t  = 11'b00010100000;
`else
    v0_t   = 11'b00000001111;
    v1_t   = 11'b00000011111;
    rdy0_t = 11'b00000001111;
    rdy1_t = 11'b00000010000;
    r0v_t  = 11'b00011110000;
    r1v_t  = 11'b00100000000;
`endif

    // ---- reset state, valids held high during reset
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    set_req0(0, 0, 0, 0);
    set_req1(0, 0, 0, 0);
    tick();
    tick();
    check("rst_ready0", req0_ready, 1'b0);
    check("rst_ready1", req1_ready, 1'b0);
    check("rst_mul_en", mul_en, 1'b0);
    check("rst_rsp0_valid", rsp0_valid, 1'b0);
    check("rst_rsp1_valid", rsp1_valid, 1'b0);
    check("rst_mul_ar", mul_ar, 0);
    check("rst_rsp0_r", rsp0_r, 0);
    check("rst_idle", idle, 1'b1);

    // ---- single request: (3+2j)*(5+1j) = 13+13j
    rst = 1'b0;
    req1_valid = 1'b0;
    set_req0(3, 2, 5, 1);
    #1;
    check("single_ready0", req0_ready, 1'b1);
    check("single_ready1", req1_ready, 1'b0);
    tick();                               // cycle A+1
    req0_valid = 1'b0;
    #1;
    check("single_mul_en", mul_en, 1'b1);
    check("single_mul_ar", mul_ar, 3);
    check("single_mul_ai", mul_ai, 2);
    check("single_mul_br", mul_br, 5);
    check("single_mul_bi", mul_bi, 1);
    check("single_busy", idle, 1'b0);
    tick();                               // A+2
    check("single_mul_en_off", mul_en, 1'b0);
    check("single_rsp0_early2", rsp0_valid, 1'b0);
    tick();                               // A+3
    check("single_rsp0_early3", rsp0_valid, 1'b0);
    tick();                               // A+4
    check("single_rsp0_valid", rsp0_valid, 1'b1);
    check("single_rsp0_r", rsp0_r, 13);
    check("single_rsp0_i", rsp0_i, 13);
    check("single_rsp1_valid", rsp1_valid, 1'b0);
    check("single_busy_rsp", idle, 1'b0);
    tick();                               // A+5
    check("single_rsp0_drop", rsp0_valid, 1'b0);
    check("single_idle", idle, 1'b1);
    check("single_rsp0_hold", rsp0_r, 13);

    // ---- tie after reset: req0 = 13+13j, req1 (-1+0j)*(4+4j) = -4-4j
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req0(3, 2, 5, 1);
    set_req1(-1, 0, 4, 4);
    for (int k = 0; k < 11; k++) begin
      req0_valid = v0_t[k];
      req1_valid = v1_t[k];
      #1;
      check($sformatf("tie_ready0_c%0d", k), req0_ready, rdy0_t[k]);
      check($sformatf("tie_ready1_c%0d", k), req1_ready, rdy1_t[k]);
      check($sformatf("tie_rsp0_valid_c%0d", k), rsp0_valid, r0v_t[k]);
      check($sformatf("tie_rsp1_valid_c%0d", k), rsp1_valid, r1v_t[k]);
      if (r0v_t[k]) begin
        check($sformatf("tie_rsp0_r_c%0d", k), rsp0_r, 13);
        check($sformatf("tie_rsp0_i_c%0d", k), rsp0_i, 13);
      end
      if (r1v_t[k]) begin
        check($sformatf("tie_rsp1_r_c%0d", k), rsp1_r, -4);
        check($sformatf("tie_rsp1_i_c%0d", k), rsp1_i, -4);
      end
      if (k == 10) check("tie_idle_end", idle, 1'b1);
      tick();
    end

    // ---- reset with two results in flight, one due on the reset edge
    set_req0(2, 1, 1, 1);
    req0_valid = 1'b1;                    // c0
    #1;
    check("rif_ready0", req0_ready, 1'b1);
    tick();
    req0_valid = 1'b0;                    // c1
    set_req1(1, 2, 3, 0);
    req1_valid = 1'b1;
    #1;
    check("rif_ready1", req1_ready, 1'b1);
    tick();
    req1_valid = 1'b0;                    // c2
    #1;
    check("rif_mul_en", mul_en, 1'b1);
    check("rif_mul_ar", mul_ar, 1);
    check("rif_busy", idle, 1'b0);
    tick();
    rst = 1'b1;                           // c3: reset cycle
    req0_valid = 1'b1;
    #1;
    check("rif_ready0_in_rst", req0_ready, 1'b0);
    tick();
    rst = 1'b0;                           // c4
    req0_valid = 1'b0;
    #1;
    check("rif_mul_en_rst", mul_en, 1'b0);
    check("rif_mul_ar_rst", mul_ar, 0);
    check("rif_mul_ai_rst", mul_ai, 0);
    check("rif_mul_br_rst", mul_br, 0);
    check("rif_mul_bi_rst", mul_bi, 0);
    check("rif_rsp0_r_rst", rsp0_r, 0);
    check("rif_rsp0_i_rst", rsp0_i, 0);
    check("rif_rsp1_r_rst", rsp1_r, 0);
    check("rif_rsp1_i_rst", rsp1_i, 0);
    check("rif_idle_rst", idle, 1'b1);
    for (int k = 4; k < 9; k++) begin
      check($sformatf("rif_rsp0_quiet_c%0d", k), rsp0_valid, 1'b0);
      check($sformatf("rif_rsp1_quiet_c%0d", k), rsp1_valid, 1'b0);
      tick();
    end

    // ---- next accept after reset, extreme operands on req1
    // (-128-128j)*(-128+127j) = 32640 + 128j
    set_req1(-128, -128, -128, 127);
    req1_valid = 1'b1;                    // c9
    #1;
    check("ext_ready1", req1_ready, 1'b1);
    tick();
    req1_valid = 1'b0;
    for (int k = 10; k < 13; k++) begin
      check($sformatf("ext_rsp1_early_c%0d", k), rsp1_valid, 1'b0);
      tick();
    end
    check("ext_rsp1_valid", rsp1_valid, 1'b1);   // c13
    check("ext_rsp1_r", rsp1_r, 32640);
    check("ext_rsp1_i", rsp1_i, 128);
    check("ext_rsp0_valid", rsp0_valid, 1'b0);
    tick();
    check("ext_idle", idle, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cmul_arbiter.md
# cmul_arbiter

Two-requester arbiter and sequencer for the shared `comp_mul` complex multiplier. Accepts operand pairs from two clients over valid/ready, issues at most one multiply per cycle, tracks ownership of every in-flight product with a tag pipeline, and returns each result to the requester that issued it. Sits directly in front of one `comp_mul` instance and owns its `i_en` and operand inputs; `comp_mul` shares `clk` and `rst`.

## Interface
- `MUL_LAT`, 2: `comp_mul` latency in cycles, from an `i_en` cycle to its result cycle; legal range 1–8.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req0_valid`, `req1_valid` input 1 each: requester has an operand pair.
- `req0_ready`, `req1_ready` output 1 each: combinational grant; a transfer occurs when valid and ready are both high at a rising edge.
- `req0_ar`, `req0_ai`, `req0_br`, `req0_bi`, and the matching `req1_*` inputs, input 8 each: operands a = ar + j·ai and b = br + j·bi, signed two's complement.
- `mul_en` output 1: drives `comp_mul` `i_en`.
- `mul_ar`, `mul_ai`, `mul_br`, `mul_bi` output 8 each: registered operands to `comp_mul`.
- `mul_or`, `mul_oi` input 17 each: `comp_mul` `o_r` and `o_i`.
- `rsp0_valid`, `rsp1_valid` output 1 each: single-cycle result strobe; no backpressure.
- `rsp0_r`, `rsp0_i`, `rsp1_r`, `rsp1_i` output 17 each: result real and imaginary parts, signed.
- `idle` output 1: no accepted request is still pending a response.

## Operation
- Grant logic is combinational. `readyN` = `reqN_valid` and (N wins arbitration). At most one ready is high per cycle. Ready never depends on downstream state, so the block accepts one request every cycle.
- Arbitration uses round-robin with a 1-bit `last` pointer.
  - If both requesters are valid, grant the one not equal to `last`.
  - If only one is valid, grant it.
  - `last` updates to the granted id on each transfer.
  - After reset `last` = 1, so requester 0 wins the first tie.
- Issue on a transfer at edge A:
  - Register the granted operands onto `mul_*` and set `mul_en` = 1 for cycle A+1.
  - Push {valid=1, id} into the tag pipeline.
  - Cycles without a transfer push {0, x}, and `mul_en` = 0. `mul_*` holds its last value.
- The tag pipeline is `MUL_LAT`+1 stages, aligned so that its head is valid in the cycle when `mul_or`/`mul_oi` carry that request's product (cycle A+1+`MUL_LAT`).
- Capture at the end of that cycle:
  - Head id = N: `rspN_r/i` <= `mul_or/oi`, `rspN_valid` <= 1.
  - The other requester's valid goes to 0 and its data holds.
- The arbiter performs no arithmetic. The 17-bit width and the signed product (ar·br − ai·bi, ar·bi + ai·br) come from `comp_mul`.
- `idle` = 1 when no tag stage holds valid and no `rspN_valid` is pending in the current cycle.

## Timing
- Latency from accept edge A to the `rspN_valid` cycle is `MUL_LAT`+2 cycles, constant. Throughput is 1 per cycle.
- Responses return in issue order. Each requester sees its own results in its own accept order.
- Reset values:
  - `mul_en`, `rsp0_valid`, `rsp1_valid` = 0.
  - All `mul_*` operands and all `rsp*_r/i` = 0.
  - Tag pipeline all invalid; `last` = 1; `idle` = 1.
- Both ready outputs are 0 while `rst` is high.
- Reset mid-operation: every in-flight tag is discarded on the reset edge. No `rsp*_valid` fires for requests accepted before reset, including when a result is due in the same cycle as the reset.
- Simultaneous events: a new transfer and a response retiring in the same cycle are independent and both occur.
- Continuous back-to-back traffic from both requesters alternates grants 0,1,0,1….

## Configuration
- `CMUL_ARB_RR_EN` defined: round-robin arbitration as described above.
- `CMUL_ARB_RR_EN` not defined: fixed priority. Requester 0 always wins ties, and the `last` pointer is not implemented. Requester 1 can starve; that is accepted in this build.
- All other behaviour is identical in both builds.

## Test plan
Run all scenarios with `MUL_LAT`=2 and a bench `comp_mul` model.
- Single request: req0 (3+2j)×(5+1j), accepted at edge A → `rsp0_valid` in cycle A+4 with `rsp0_r`=13 and `rsp0_i`=13. `rsp1_valid` stays 0. `idle` returns to 1.
- Tie after reset: both requesters hold valid for 4 cycles, req1 operands (−1+0j)×(4+4j) → grants 0,1,0,1. `rsp1` = −4−4j. Each response arrives 4 cycles after its grant.
- Fixed priority (macro undefined): same stimulus as the tie test → req0 granted all 4 cycles and `req1_ready` stays 0 until `req0_valid` drops.
- Reset with results in flight: assert `rst` for 1 cycle, 2 cycles after two accepts → no `rsp*_valid` pulses afterward. All outputs read reset values. The next accept returns correctly after 4 cycles.
- Extreme operands: req1 (−128−128j)×(−128+127j) → `rsp1_r` = 32640 and `rsp1_i` = 128, passed through at full 17 bits with no truncation.
